// File: rtl/shift_result_if.sv
// Handshake bundle between the shifter output stage and writeback.
// Ports:
//   in_valid/in_ready    issue-side handshake
//   in_operand/in_shift  shifter inputs (operand and signed shift amount)
//   in_result/in_tag     shifter output and destination register tag
//   flush                synchronous discard of all held entries
//   out_valid/out_ready  writeback-side handshake
//   out_result/out_tag   registered result and tag
//   out_z/out_n/out_c    registered zero / negative / carry-out flags
interface shift_result_if #(
   parameter int unsigned TAG_W = 3
) ();
   logic             in_valid;
   logic             in_ready;
   logic [15:0]      in_operand;
   logic [4:0]       in_shift;
   logic [15:0]      in_result;
   logic [TAG_W-1:0] in_tag;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [15:0]      out_result;
   logic [TAG_W-1:0] out_tag;
   logic             out_z;
   logic             out_n;
   logic             out_c;

   // Producer/consumer side (issue logic + writeback)
   modport master (
      output in_valid, in_operand, in_shift, in_result, in_tag, flush, out_ready,
      input  in_ready, out_valid, out_result, out_tag, out_z, out_n, out_c
   );

   // Result stage side
   modport slave (
      input  in_valid, in_operand, in_shift, in_result, in_tag, flush, out_ready,
      output in_ready, out_valid, out_result, out_tag, out_z, out_n, out_c
   );
endinterface

// File: rtl/shift_result_stage.sv
// Registered stage behind the 16-bit shifter: captures result + tag, derives
// Z/N/C flags, and hands entries to writeback through an output register
// backed by a one-entry skid register.
// Ports:
//   clk  system clock, all state on rising edge
//   rst  synchronous active-high reset
//   bus  shift_result_if.slave (issue handshake, flush, writeback handshake)
module shift_result_stage #(
   parameter int unsigned TAG_W = 3
) (
   input logic           clk,
   input logic           rst,
   shift_result_if.slave bus
);
   localparam int unsigned DATA_W = 16;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   typedef struct packed {
      logic [DATA_W-1:0] result;
      logic [TAG_W-1:0]  tag;
      logic              z;
      logic              n;
      logic              c;
   } entry_t;

   state_t state;
   state_t state_nxt;
   entry_t in_entry_c;
   entry_t or_q;
   entry_t sk_q;
   logic   in_ready_q;
   logic   out_valid_q;
   logic   accept_c;
   logic   drain_c;
   logic   load_or_in_c;
   logic   load_or_sk_c;
   logic   load_sk_c;
   logic [3:0] left_idx_c;
   logic [3:0] right_idx_c;
   logic   carry_c;

   // Carry-out: left shift by s leaves bit 16-s last; right shift by -s
   // leaves bit -s-1 last, which is simply the bitwise inverse of s.
   always_comb begin
      left_idx_c  = 4'(5'd16 - bus.in_shift);
      right_idx_c = 4'(~bus.in_shift);
      carry_c     = 1'b0;
      if (bus.in_shift == 5'd0) begin
         carry_c = 1'b0;
      end else if (!bus.in_shift[4]) begin
         carry_c = bus.in_operand[left_idx_c];
      end else begin
         carry_c = bus.in_operand[right_idx_c];
      end
   end

   // Incoming entry with flags computed from the shifter output as given
   always_comb begin
      in_entry_c.result = bus.in_result;
      in_entry_c.tag    = bus.in_tag;
      in_entry_c.z      = (bus.in_result == 16'h0000);
      in_entry_c.n      = bus.in_result[15];
      in_entry_c.c      = carry_c;
   end

   // State register; ready/valid are registered images of the next state
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state       <= state_nxt;
         in_ready_q  <= (state_nxt != FULL);
         out_valid_q <= (state_nxt != EMPTY);
      end
   end

   // Next-state and register load selection; flush discards everything
   always_comb begin
      state_nxt    = state;
      load_or_in_c = 1'b0;
      load_or_sk_c = 1'b0;
      load_sk_c    = 1'b0;
      accept_c     = bus.in_valid && in_ready_q;
      drain_c      = out_valid_q && bus.out_ready;
      if (bus.flush) begin
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (accept_c) begin
                  state_nxt    = ONE;
                  load_or_in_c = 1'b1;
               end
            end
            ONE: begin
               if (accept_c && drain_c) begin
                  load_or_in_c = 1'b1;
               end else if (accept_c) begin
                  state_nxt = FULL;
                  load_sk_c = 1'b1;
               end else if (drain_c) begin
                  state_nxt = EMPTY;
               end
            end
            FULL: begin
               // in_ready is low here, so only a drain can move things
               if (drain_c) begin
                  state_nxt    = ONE;
                  load_or_sk_c = 1'b1;
               end
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end

   // Data registers; contents are don't-care while their slot is invalid
   always_ff @(posedge clk) begin
      if (rst) begin
         or_q <= '0;
         sk_q <= '0;
      end else begin
         if (load_or_in_c) begin
            or_q <= in_entry_c;
         end else if (load_or_sk_c) begin
            or_q <= sk_q;
         end
         if (load_sk_c) begin
            sk_q <= in_entry_c;
         end
      end
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_result = or_q.result;
   assign bus.out_tag    = or_q.tag;
   assign bus.out_z      = or_q.z;
   assign bus.out_n      = or_q.n;
   assign bus.out_c      = or_q.c;
endmodule

// File: tb/tb_shift_result_stage.sv
// Testbench for shift_result_stage: directed scenarios plus random traffic,
// checked against a queue-based reference model.
module tb_shift_result_stage;
   logic clk;
   logic rst;

   shift_result_if #(.TAG_W(3)) bus ();

   shift_result_stage #(.TAG_W(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   typedef struct {
      logic [15:0] result;
      logic [2:0]  tag;
      logic        z;
      logic        n;
      logic        c;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   known = 1'b0;
   bit   chk_rst = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // True shift: positive = left, negative = logical right
   function automatic logic [15:0] ref_shift(input logic [15:0] op, input logic [4:0] sh);
      int s;
      logic [31:0] w;
      s = int'($signed(sh));
      w = {16'h0, op};
      if (s >= 0) w = w << s;
      else        w = w >> (-s);
      return w[15:0];
   endfunction

   // Expected entry: carry is the last bit to leave the 16-bit window
   function automatic exp_t model(input logic [15:0] op, input logic [4:0] sh,
                                  input logic [15:0] res, input logic [2:0] tag);
      int s;
      logic [31:0] w;
      exp_t e;
      s = int'($signed(sh));
      e.c = 1'b0;
      if (s > 0) begin
         w = {16'h0, op} << s;
         e.c = w[16];
      end else if (s < 0) begin
         w = {op, 16'h0} >> (-s);
         e.c = w[15];
      end
      e.result = res;
      e.tag    = tag;
      e.z      = (res == 16'h0);
      e.n      = res[15];
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor + model update, sampled mid-cycle when everything is stable
   always @(negedge clk) begin
      bit acc;
      bit drn;
      if (known) begin
         chk("in_ready", 32'(bus.in_ready), 32'(sb_q.size() < 2));
         chk("out_valid", 32'(bus.out_valid), 32'(sb_q.size() > 0));
         if (chk_rst) begin
            chk("rst_result", 32'(bus.out_result), 32'h0);
            chk("rst_tag", 32'(bus.out_tag), 32'h0);
            chk("rst_z", 32'(bus.out_z), 32'h0);
            chk("rst_n", 32'(bus.out_n), 32'h0);
            chk("rst_c", 32'(bus.out_c), 32'h0);
         end
         if (sb_q.size() > 0 && bus.out_valid) begin
            chk("out_result", 32'(bus.out_result), 32'(sb_q[0].result));
            chk("out_tag", 32'(bus.out_tag), 32'(sb_q[0].tag));
            chk("out_z", 32'(bus.out_z), 32'(sb_q[0].z));
            chk("out_n", 32'(bus.out_n), 32'(sb_q[0].n));
            chk("out_c", 32'(bus.out_c), 32'(sb_q[0].c));
         end
      end
      acc = bus.in_valid && (sb_q.size() < 2);
      drn = bus.out_ready && (sb_q.size() > 0);
      if (rst) begin
         sb_q.delete();
         chk_rst = 1'b1;
         known   = 1'b1;
      end else begin
         chk_rst = 1'b0;
         if (bus.flush) begin
            sb_q.delete();
         end else begin
            if (drn) void'(sb_q.pop_front());
            if (acc) sb_q.push_back(model(bus.in_operand, bus.in_shift, bus.in_result, bus.in_tag));
         end
      end
   end

   // Present one entry and hold it until the stage takes it
   task automatic issue(input logic [15:0] op, input logic [4:0] sh,
                        input logic [15:0] res, input logic [2:0] tag);
      bit done;
      int n;
      done = 1'b0;
      n = 0;
      bus.in_valid   = 1'b1;
      bus.in_operand = op;
      bus.in_shift   = sh;
      bus.in_result  = res;
      bus.in_tag     = tag;
      while (!done) begin
         @(negedge clk);
         done = bus.in_ready;
         @(posedge clk);
         #1;
         n++;
         if (!done && n > 100) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout actual=stalled expected=accepted at %0t", $time);
            done = 1'b1;
         end
      end
   endtask

   task automatic issue_rand(input logic [2:0] tag);
      logic [15:0] op;
      logic [4:0]  sh;
      op = 16'($urandom);
      sh = 5'($urandom);
      issue(op, sh, ref_shift(op, sh), tag);
   endtask

   task automatic idle(input int n);
      bus.in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      rst            = 1'b1;
      bus.flush      = 1'b0;
      bus.in_valid   = 1'b0;
      bus.in_operand = 16'h0;
      bus.in_shift   = 5'h0;
      bus.in_result  = 16'h0;
      bus.in_tag     = 3'h0;
      bus.out_ready  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      idle(1);

      // Flag extremes
      issue(16'h8001, 5'b00001, 16'h0002, 3'd5);
      idle(1);
      issue(16'h8001, 5'b11111, 16'h4000, 3'd1);
      issue(16'h8000, 5'b10000, 16'h0000, 3'd2);
      issue(16'h0002, 5'b01111, 16'h0000, 3'd3);
      issue(16'hFFFF, 5'b00000, 16'hFFFF, 3'd4);
      idle(3);

      // Backpressure: fill both slots, hold a third until space opens
      bus.out_ready = 1'b0;
      issue(16'h1111, 5'd0, 16'h1111, 3'd1);
      issue(16'h2222, 5'd0, 16'h2222, 3'd2);
      fork
         issue(16'h3333, 5'd0, 16'h3333, 3'd3);
         begin
            repeat (3) @(posedge clk);
            #1;
            bus.out_ready = 1'b1;
         end
      join
      idle(4);

      // Back-to-back streaming
      for (int i = 0; i < 8; i++) issue_rand(3'(i));
      idle(3);

      // Flush while FULL with a pending input
      bus.out_ready = 1'b0;
      issue_rand(3'd6);
      issue_rand(3'd7);
      bus.in_valid = 1'b1;
      bus.in_result = 16'hDEAD;
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      bus.out_ready = 1'b1;
      idle(3);

      // Flush while ONE overrides a simultaneous accept
      bus.out_ready = 1'b0;
      issue_rand(3'd1);
      bus.in_valid = 1'b1;
      bus.in_result = 16'hBEEF;
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      bus.out_ready = 1'b1;
      idle(3);

      // Reset while FULL
      bus.out_ready = 1'b0;
      issue_rand(3'd2);
      issue_rand(3'd3);
      bus.in_valid = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.out_ready = 1'b1;
      idle(3);

      // Random traffic with occasional flushes
      for (int i = 0; i < 400; i++) begin
         logic [15:0] op;
         logic [4:0]  sh;
         op = 16'($urandom);
         sh = 5'($urandom);
         bus.in_valid   = ($urandom_range(0, 3) != 0);
         bus.in_operand = op;
         bus.in_shift   = sh;
         bus.in_result  = ref_shift(op, sh);
         bus.in_tag     = 3'($urandom);
         bus.out_ready  = ($urandom_range(0, 2) != 0);
         bus.flush      = ($urandom_range(0, 39) == 0);
         @(posedge clk);
         #1;
      end
      bus.flush = 1'b0;
      bus.out_ready = 1'b1;
      idle(5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
